// File: rtl/imem_boot_loader.sv
// imem_boot_loader: length-prefixed byte-stream loader for the instruction memory.
// Holds the core in reset, writes each program byte to consecutive imem
// addresses starting at 0, then releases the core.
// Build option: define LOADER_CHECKSUM_EN to require a trailing mod-256
// checksum byte before the core is released.
module imem_boot_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              im_wr,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] LEN_MAX = DATA_W'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERR} state_t;
`else
   typedef enum logic [2:0] {LEN, DATA, RUN, ERR} state_t;
`endif

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              last_byte;
   logic [ADDR_W-1:0] idx;       // address of the next program byte
   logic [ADDR_W-1:0] last_idx;  // length minus one; holds the stored count
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;       // running mod-256 sum of program bytes
   logic [DATA_W-1:0] sum_chk;   // sum including the byte on the bus

   assign sum_chk = sum + in_data;
`endif

   assign accept    = in_valid && in_ready;
   assign last_byte = (idx == last_idx);

   // Next-state decode and the ready handshake, both derived from state.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         LEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data != '0 && in_data <= LEN_MAX) state_next = DATA;
               else                                     state_next = ERR;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (in_valid && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = CSUM;
`else
               state_next = RUN;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            if (in_valid) state_next = (sum_chk == '0) ? RUN : ERR;
         end
`endif
         RUN, ERR: begin
            // terminal until reset
         end
         default: state_next = ERR;  // unreachable encodings never release the core
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential logic uses non-blocking assignments so every
      // register samples the values from before the clock edge.
      if (reset) state <= LEN;
      else       state <= state_next;
   end

   // Write port, byte counters and core-control outputs; the release and
   // error flags follow the state one edge later so the last write has
   // committed before the core leaves reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         last_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum       <= '0;
`endif
         im_wr     <= 1'b0;
         im_waddr  <= '0;
         im_wdata  <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         im_wr     <= 1'b0;
         cpu_reset <= (state != RUN);
         done      <= (state == RUN);
         err       <= (state == ERR);
         if (accept) begin
            case (state)
               LEN: begin
                  // An illegal length leaves for ERR, so this value is unused then.
                  last_idx <= ADDR_W'(in_data - DATA_W'(1));
                  idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= '0;
`endif
               end
               DATA: begin
                  im_wr    <= 1'b1;
                  im_waddr <= idx;
                  im_wdata <= in_data;
                  idx      <= idx + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum_chk;
`endif
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader. Expected writes are queued as
// bytes are driven and compared when the DUT pulses im_wr.
module tb_imem_boot_loader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              im_wr;
   logic [ADDR_W-1:0] im_waddr;
   logic [DATA_W-1:0] im_wdata;
   logic              cpu_reset;
   logic              done;
   logic              err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_count = 0;
   bit          mon_en = 1'b0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  prog[$];

   imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .im_wr     (im_wr),
      .im_waddr  (im_waddr),
      .im_wdata  (im_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: pop one expected write per im_wr pulse; also hold
   // the core-release invariants on every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check("cpu_reset_vs_done", cpu_reset, !done);
         check("done_and_err", done & err, 1'b0);
         if (im_wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", im_waddr, mon_e.addr);
               check("wr_data", im_wdata, mon_e.data);
            end
         end
      end
   end

   // Drive one byte and hold it until the DUT accepts it; returns at posedge+1.
   task automatic push_byte(input logic [7:0] b);
      bit rdy;
      int tries;
      rdy = 1'b0;
      tries = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!rdy && tries < 64) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!rdy) check("ready_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_im_wr"},     im_wr,     1'b0);
      check({tag, "_im_waddr"},  im_waddr,  '0);
      check({tag, "_im_wdata"},  im_wdata,  '0);
      check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
      check({tag, "_done"},      done,      1'b0);
      check({tag, "_err"},       err,       1'b0);
      check({tag, "_in_ready"},  in_ready,  1'b1);
   endtask

   // Load the program held in prog; with checksumming, a good or bad
   // trailing byte is appended. Checks release timing at the end.
   task automatic do_load(input int gap_max, input bit csum_good);
      logic [7:0] s;
      int w0;
      bit ok;
      w0 = wr_count;
      s  = 8'h00;
      ok = !CSUM_ON || csum_good;
      push_byte(8'(prog.size()));
      foreach (prog[i]) begin
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
         exp_q.push_back('{addr: ADDR_W'(i), data: prog[i]});
         s = s + prog[i];
         push_byte(prog[i]);
      end
      if (CSUM_ON) push_byte(csum_good ? 8'(8'h00 - s) : 8'(8'h00 - s - 8'h01));
      @(negedge clk);
      check("final_wr_pulse", im_wr, !CSUM_ON);
      check("cpu_reset_held", cpu_reset, 1'b1);
      check("done_early", done, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("cpu_reset_release", cpu_reset, !ok);
      check("done", done, ok);
      check("err", err, !ok);
      check("in_ready_end", in_ready, 1'b0);
      check("wr_count", wr_count - w0, prog.size());
      check("queue_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_bad_len(input logic [7:0] len);
      int w0;
      do_reset();
      w0 = wr_count;
      push_byte(len);
      @(negedge clk);
      check("badlen_ready", in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("badlen_err", err, 1'b1);
      check("badlen_cpu_reset", cpu_reset, 1'b1);
      check("badlen_done", done, 1'b0);
      #1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      idle(3);
      in_valid = 1'b0;
      @(negedge clk);
      check("badlen_no_wr", wr_count - w0, 0);
      check("badlen_err_sticky", err, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int w0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Nine-byte program, back-to-back
      prog = '{8'h22, 8'h41, 8'h83, 8'hC0, 8'h22, 8'h61, 8'h83, 8'hE0, 8'hA0};
      do_load(0, 1'b1);

      // Bytes offered after release are ignored
      w0 = wr_count;
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (4) begin
         @(negedge clk);
         check("run_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("run_no_wr", wr_count - w0, 0);
      check("run_done_hold", done, CSUM_ON ? 1'b1 : 1'b1);

      // Illegal lengths
      do_bad_len(8'h00);
      do_bad_len(8'h21);

      // Length-5 load with random valid gaps
      do_reset();
      prog.delete();
      repeat (5) prog.push_back(8'($urandom));
      do_load(3, 1'b1);

      // Reset in the middle of a length-8 load
      do_reset();
      w0 = wr_count;
      push_byte(8'd8);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{addr: ADDR_W'(i), data: 8'(8'h10 + i)});
         push_byte(8'(8'h10 + i));
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midrst");
      check("midrst_writes", wr_count - w0, 3);
      check("midrst_queue", exp_q.size(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Full-depth load right after reset drops
      prog.delete();
      repeat (32) prog.push_back(8'($urandom));
      do_load(2, 1'b1);
      check("full_last_addr", im_waddr, 5'd31);

`ifdef LOADER_CHECKSUM_EN
      // Checksum accepted and rejected
      do_reset();
      prog = '{8'h22, 8'h41};
      do_load(0, 1'b1);
      do_reset();
      do_load(0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
